// File: rtl/rf_pkg.sv
// Shared state encoding and default geometry for the register-file port sequencer.
package rf_pkg;

  localparam int RF_N_REGS = 8;
  localparam int RF_ADDR_W = 3;
  localparam int RF_DATA_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RESP,
    ACCESS
  } rf_state_e;

endpackage

// File: rtl/rf_addr_decoder.sv
// Binary address to one-hot word strobe; all-zero when disabled or the address has no word behind it.
module rf_addr_decoder
  import rf_pkg::*;
#(
  parameter int N_REGS = RF_N_REGS,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [N_REGS-1:0] o_onehot
);

  // Comparing against each real word index leaves out-of-range addresses with no hit.
  always_comb begin
    o_onehot = '0;
    for (int k = 0; k < N_REGS; k++) begin
      o_onehot[k] = i_en && (i_addr == ADDR_W'(k));
    end
  end

endmodule

// File: rtl/rf_port_sequencer.sv
// Sequences one request at a time into W/I then Ra/Rb strobes for the cell array (RF_BYPASS_EN merges both into ACCESS).
// Latency: write+read 2 cycles (1 with RF_BYPASS_EN), read-only 1 cycle, write-only frees req_ready after 1 cycle.
// Backpressure: req_ready only in IDLE, nothing queued; rsp_valid holds with stable data until rsp_ready.
module rf_port_sequencer
  import rf_pkg::*;
#(
  parameter int N_REGS = RF_N_REGS,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_waddr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_ra_en,
  input  logic              req_rb_en,
  input  logic [ADDR_W-1:0] req_ra_addr,
  input  logic [ADDR_W-1:0] req_rb_addr,
  output logic [N_REGS-1:0] W,
  output logic [N_REGS-1:0] Ra,
  output logic [N_REGS-1:0] Rb,
  output logic [DATA_W-1:0] I,
  input  logic [DATA_W-1:0] Oa,
  input  logic [DATA_W-1:0] Ob,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_a,
  output logic [DATA_W-1:0] rsp_b
);

  rf_state_e         r_state;
  rf_state_e         w_next_state;

  logic              r_we;
  logic              r_ra_en;
  logic              r_rb_en;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_ra_addr;
  logic [ADDR_W-1:0] r_rb_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rsp_a;
  logic [DATA_W-1:0] r_rsp_b;

  logic              w_accept;
  logic              w_wr_en;
  logic              w_rda_en;
  logic              w_rdb_en;
  logic              w_sample;
  logic              w_drive_i;
  logic [N_REGS-1:0] w_w_oh;
  logic [N_REGS-1:0] w_ra_oh;
  logic [N_REGS-1:0] w_rb_oh;
  logic [DATA_W-1:0] w_next_a;
  logic [DATA_W-1:0] w_next_b;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    w_accept     = 1'b0;
    w_wr_en      = 1'b0;
    w_rda_en     = 1'b0;
    w_rdb_en     = 1'b0;
    w_sample     = 1'b0;
    w_drive_i    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
`ifdef RF_BYPASS_EN
          if (req_we || req_ra_en || req_rb_en) begin
            w_next_state = ACCESS;
          end
`else
          if (req_we) begin
            w_next_state = WRITE;
          end else if (req_ra_en || req_rb_en) begin
            w_next_state = READ;
          end
`endif
        end
      end
      WRITE: begin
        w_wr_en      = r_we;
        w_drive_i    = r_we;
        w_next_state = (r_ra_en || r_rb_en) ? READ : IDLE;
      end
      READ: begin
        w_rda_en     = r_ra_en;
        w_rdb_en     = r_rb_en;
        w_sample     = 1'b1;
        w_next_state = RESP;
      end
`ifdef RF_BYPASS_EN
      ACCESS: begin
        w_wr_en      = r_we;
        w_drive_i    = r_we;
        w_rda_en     = r_ra_en;
        w_rdb_en     = r_rb_en;
        w_sample     = r_ra_en || r_rb_en;
        w_next_state = (r_ra_en || r_rb_en) ? RESP : IDLE;
      end
`endif
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_we      <= 1'b0;
      r_ra_en   <= 1'b0;
      r_rb_en   <= 1'b0;
      r_waddr   <= '0;
      r_ra_addr <= '0;
      r_rb_addr <= '0;
      r_wdata   <= '0;
    end else if (w_accept) begin
      r_we      <= req_we;
      r_ra_en   <= req_ra_en;
      r_rb_en   <= req_rb_en;
      r_waddr   <= req_waddr;
      r_ra_addr <= req_ra_addr;
      r_rb_addr <= req_rb_addr;
      r_wdata   <= req_wdata;
    end
  end

  rf_addr_decoder #(.N_REGS(N_REGS), .ADDR_W(ADDR_W)) u_dec_w (
    .i_en     (w_wr_en),
    .i_addr   (r_waddr),
    .o_onehot (w_w_oh)
  );

  rf_addr_decoder #(.N_REGS(N_REGS), .ADDR_W(ADDR_W)) u_dec_ra (
    .i_en     (w_rda_en),
    .i_addr   (r_ra_addr),
    .o_onehot (w_ra_oh)
  );

  rf_addr_decoder #(.N_REGS(N_REGS), .ADDR_W(ADDR_W)) u_dec_rb (
    .i_en     (w_rdb_en),
    .i_addr   (r_rb_addr),
    .o_onehot (w_rb_oh)
  );

  // A port with no strobe leaves its bus floating, so only a decoded hit may be sampled.
  always_comb begin
    w_next_a = (|w_ra_oh) ? Oa : '0;
    w_next_b = (|w_rb_oh) ? Ob : '0;
`ifdef RF_BYPASS_EN
    if ((|w_ra_oh) && (|w_w_oh) && (r_ra_addr == r_waddr)) begin
      w_next_a = r_wdata;
    end
    if ((|w_rb_oh) && (|w_w_oh) && (r_rb_addr == r_waddr)) begin
      w_next_b = r_wdata;
    end
`endif
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rsp_a <= '0;
      r_rsp_b <= '0;
    end else if (w_sample) begin
      r_rsp_a <= w_next_a;
      r_rsp_b <= w_next_b;
    end
  end

  assign W     = w_w_oh;
  assign Ra    = w_ra_oh;
  assign Rb    = w_rb_oh;
  assign I     = w_drive_i ? r_wdata : '0;
  assign rsp_a = r_rsp_a;
  assign rsp_b = r_rsp_b;

  a_w_onehot : assert property (@(posedge Clk) disable iff (!Rst_n) $onehot0(W));
  a_ra_onehot : assert property (@(posedge Clk) disable iff (!Rst_n) $onehot0(Ra));
  a_rb_onehot : assert property (@(posedge Clk) disable iff (!Rst_n) $onehot0(Rb));
`ifndef RF_BYPASS_EN
  a_no_read_on_write : assert property (@(posedge Clk) disable iff (!Rst_n)
    !((|W) && ((|Ra) || (|Rb))));
`endif
  a_rsp_hold : assert property (@(posedge Clk) disable iff (!Rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_a) && $stable(rsp_b)));

endmodule

// File: doc/rf_port_sequencer.md
# rf_port_sequencer

Front-end controller that sits directly upstream of the register-file cell array. It accepts one access request at a time over a valid/ready handshake and generates the per-word write strobes (W), read strobes (Ra, Rb) and write data bus (I) for the cells. It samples the tri-state read buses (Oa, Ob) and returns the read data over a second valid/ready handshake. Each word is DATA_W cells sharing one W/Ra/Rb line.

## Interface
- N_REGS, 8, number of words in the array
- ADDR_W, 3, address width; must satisfy 2^ADDR_W >= N_REGS
- DATA_W, 4, bits per word (cells per word)

- Clk  in  1  system clock; all state updates on the rising edge
- Rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_we  in  1  request includes a write
- req_waddr  in  ADDR_W  write address
- req_wdata  in  DATA_W  write data
- req_ra_en / req_rb_en  in  1 each  read port A / B requested
- req_ra_addr / req_rb_addr  in  ADDR_W each  read addresses
- W  out  N_REGS  one-hot write strobes to the cells
- Ra / Rb  out  N_REGS each  one-hot tri-state enables for the port A / B buses
- I  out  DATA_W  write data bus to the cells
- Oa / Ob  in  DATA_W each  shared tri-state read buses from the cells
- rsp_valid  out  1  read response present
- rsp_ready  in  1  consumer accepts the response
- rsp_a / rsp_b  out  DATA_W each  read results

## Operation
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid, capture all request fields.
  - Next state: WRITE if req_we, else READ if any read enable is set, else stay in IDLE.
- WRITE:
  - Assert W[waddr] and drive I=wdata for exactly one cycle; the cell updates on the closing edge.
  - Next state: READ if any read enable is set, else IDLE.
- READ:
  - Assert Ra[ra_addr] only if ra_en, and Rb[rb_addr] only if rb_en, for exactly one cycle.
  - Sample Oa/Ob into rsp_a/rsp_b on the closing edge.
  - A disabled port's result is 0. The floating bus is never sampled.
- RESP:
  - rsp_valid=1. rsp_a/rsp_b are held stable until rsp_ready.
  - After the handshake, go to IDLE.
- Read-after-write within one request returns the newly written data.
- Address >= N_REGS:
  - No strobe is asserted.
  - The write is dropped; the read returns 0.
- At most one bit of each of W, Ra and Rb is ever high. All three are all-zero outside WRITE/READ.
- I is 0 when not in WRITE.
- Ra/Rb are never high in the same cycle as W, so the cells never read and write in one cycle. This rule is relaxed under the bypass configuration.

## Timing
- Reset values: req_ready=1 once Rst_n deasserts; W=Ra=Rb=0, I=0, rsp_valid=0, rsp_a=rsp_b=0; state IDLE.
- Request accepted at edge T:
  - Write+read: WRITE during T..T+1, READ during T+1..T+2, rsp_valid from T+2. Latency 2 cycles.
  - Read-only: rsp_valid from T+1. Latency 1 cycle.
  - Write-only: req_ready returns at T+1.
- req_ready=0 in WRITE, READ and RESP. No request is queued.
- rsp_ready held low stalls in RESP indefinitely, with data stable.
- Rst_n asserted mid-operation: the in-flight request is discarded. Outputs go to reset values immediately (asynchronously). A partially sequenced write either completed on a prior edge or never happened.

## Configuration
- RF_BYPASS_EN defined:
  - WRITE and READ merge into one state, ACCESS.
  - W, Ra and Rb are asserted in the same cycle.
  - A read port whose address equals waddr (with we set) returns req_wdata instead of the bus value.
  - Write+read latency becomes 1 cycle.
- RF_BYPASS_EN undefined: sequencing is exactly as described above.

## Structure
- Package rf_pkg holds:
  - the state enum (IDLE, WRITE, READ, RESP, ACCESS)
  - default N_REGS/ADDR_W/DATA_W constants
- Sub-module rf_addr_decoder: address + enable in, N_REGS-wide one-hot out, zero on out-of-range. It is instantiated three times (W, Ra, Rb).

## Test plan
- Reset: hold Rst_n=0 with req_valid=1 -> W=Ra=Rb=0, rsp_valid=0, no state change; after release, req_ready=1.
- Write reg 5=0xA, read A=5, B=2 (reg 2 preloaded 0x3) -> W=8'b0010_0000 for one cycle, then Ra=8'b0010_0000 and Rb=8'b0000_0100; rsp_a=0xA, rsp_b=0x3, latency 2 (1 with RF_BYPASS_EN).
- Read-only, A=7 enabled, B disabled -> W never asserted, Rb=0, rsp_b=0, rsp_a=reg7 one cycle after acceptance.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready=0 throughout; accepted on the first cycle rsp_ready=1.
- N_REGS=6, write address 7, read A=6 -> no strobes asserted, rsp_a=0, array contents unchanged.
- Rst_n pulsed low during READ -> rsp_valid never rises, strobes cleared immediately, the next request completes normally.
